// File: rtl/muldiv_if.sv
// rtl/muldiv_if.sv - operand, control and HI/LO result bundle for the muldiv unit
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [1:0]       op;
    logic             start;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div0;

    modport master (
        output A, B, op, start, hi_we, lo_we, wdata,
        input  busy, done, hi, lo, div0
    );

    modport slave (
        input  A, B, op, start, hi_we, lo_we, wdata,
        output busy, done, hi, lo, div0
    );
endinterface

// File: rtl/muldiv.sv
// rtl/muldiv.sv - iterative MULT/MULTU/DIV/DIVU unit with HI/LO, optional MULDIV_DIVZERO_EN flag
module muldiv #(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     reset,
    muldiv_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t               r_state;
    logic [CW-1:0]        r_cnt;
    logic [1:0]           r_op;
    logic                 r_sign_a;
    logic                 r_sign_b;
    logic                 r_bzero;
    logic [WIDTH-1:0]     r_a_raw;
    // multiplicand for multiply, divisor for divide
    logic [WIDTH-1:0]     r_opnd;
    // multiply: {partial product, remaining multiplier}; divide: {remainder, dividend/quotient}
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic                 r_busy;
    logic                 r_done;

    // op[0]=1 is the unsigned variant, op[1]=1 is divide
    logic                 w_sign_a;
    logic                 w_sign_b;
    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;
    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH-1:0]   w_mul_next;
    logic [WIDTH:0]       w_div_shift;
    logic [WIDTH:0]       w_div_diff;
    logic [2*WIDTH-1:0]   w_div_next;
    logic [2*WIDTH-1:0]   w_acc_next;
    logic [WIDTH-1:0]     w_res_hi;
    logic [WIDTH-1:0]     w_res_lo;
    logic                 w_last;

    assign w_sign_a = ~bus.op[0] & bus.A[WIDTH-1];
    assign w_sign_b = ~bus.op[0] & bus.B[WIDTH-1];
    assign w_a_mag  = w_sign_a ? -bus.A : bus.A;
    assign w_b_mag  = w_sign_b ? -bus.B : bus.B;
    assign w_last   = (r_state == S_RUN) && (r_cnt == CW'(1));

    // one shift-add multiply step and one restoring divide step; op selects which is kept
    always_comb begin
        w_mul_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_opnd : {WIDTH{1'b0}})};
        w_mul_next  = {w_mul_sum, r_acc[WIDTH-1:1]};
        w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
        w_div_diff  = w_div_shift - {1'b0, r_opnd};
        if (w_div_diff[WIDTH])
            w_div_next = {w_div_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
        else
            w_div_next = {w_div_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
        w_acc_next = r_op[1] ? w_div_next : w_mul_next;
    end

    // sign correction of the final iteration; divide-by-zero bypasses it entirely
    always_comb begin
        w_res_hi = w_acc_next[2*WIDTH-1:WIDTH];
        w_res_lo = w_acc_next[WIDTH-1:0];
        if (!r_op[1]) begin
            if (r_sign_a ^ r_sign_b)
                {w_res_hi, w_res_lo} = -w_acc_next;
        end else if (r_bzero) begin
            w_res_hi = r_a_raw;
            w_res_lo = {WIDTH{1'b1}};
        end else begin
            if (r_sign_a ^ r_sign_b)
                w_res_lo = -w_acc_next[WIDTH-1:0];
            if (r_sign_a)
                w_res_hi = -w_acc_next[2*WIDTH-1:WIDTH];
        end
    end

    // control FSM: operand capture, iteration, HI/LO writeback and MTHI/MTLO
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_op     <= 2'b00;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_bzero  <= 1'b0;
            r_a_raw  <= '0;
            r_opnd   <= '0;
            r_acc    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state  <= S_RUN;
                        r_busy   <= 1'b1;
                        r_cnt    <= CW'(WIDTH);
                        r_op     <= bus.op;
                        r_sign_a <= w_sign_a;
                        r_sign_b <= w_sign_b;
                        r_bzero  <= (bus.B == '0);
                        r_a_raw  <= bus.A;
                        r_opnd   <= bus.op[1] ? w_b_mag : w_a_mag;
                        r_acc    <= {{WIDTH{1'b0}}, (bus.op[1] ? w_a_mag : w_b_mag)};
                    end else begin
                        if (bus.hi_we)
                            r_hi <= bus.wdata;
                        if (bus.lo_we)
                            r_lo <= bus.wdata;
                    end
                end
                S_RUN: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt - CW'(1);
                    if (w_last) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_hi    <= w_res_hi;
                        r_lo    <= w_res_lo;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef MULDIV_DIVZERO_EN
    logic r_div0;

    // sticky until the next completion: set by a divide with zero divisor, cleared by anything else
    always_ff @(posedge clk) begin
        if (reset)
            r_div0 <= 1'b0;
        else if (w_last)
            r_div0 <= r_op[1] & r_bzero;
    end

    assign bus.div0 = r_div0;
`else
    assign bus.div0 = 1'b0;
`endif

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;
endmodule

// File: tb/tb_muldiv.sv
// tb/tb_muldiv.sv - scoreboard bench for muldiv with directed vectors
module tb_muldiv;
    localparam int W = 32;
`ifdef MULDIV_DIVZERO_EN
    localparam logic DZ = 1'b1;
`else
    localparam logic DZ = 1'b0;
`endif

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         d0;
        string        name;
    } exp_t;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;
    exp_t sb[$];
    exp_t mon_e;

    muldiv_if #(.WIDTH(W)) u_if ();

    muldiv #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // monitor: every done pulse must match the oldest expected result
    always @(negedge clk) begin
        if (!reset && u_if.done) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 expected no result pending");
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.name, "_hi"}, u_if.hi, mon_e.hi);
                check({mon_e.name, "_lo"}, u_if.lo, mon_e.lo);
                check({mon_e.name, "_div0"}, {31'b0, u_if.div0}, {31'b0, mon_e.d0});
            end
        end
    end

    task automatic start_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                            input bit push, input logic [W-1:0] eh, input logic [W-1:0] el,
                            input logic ed, input string name);
        exp_t e;
        if (push) begin
            e.hi = eh; e.lo = el; e.d0 = ed; e.name = name;
            sb.push_back(e);
        end
        u_if.op = op; u_if.A = a; u_if.B = b; u_if.start = 1'b1;
        @(posedge clk);
        #1 u_if.start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (u_if.done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: got no done expected done within 40 cycles", name);
        end
    endtask

    initial begin
        int bad;
        int dones;
        n_tests = 0;
        n_fail  = 0;
        reset = 1'b1;
        u_if.A = '0; u_if.B = '0; u_if.op = 2'b00; u_if.start = 1'b0;
        u_if.hi_we = 1'b0; u_if.lo_we = 1'b0; u_if.wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {31'b0, u_if.busy}, 32'd0);
        check("rst_done", {31'b0, u_if.done}, 32'd0);
        check("rst_hi", u_if.hi, 32'd0);
        check("rst_lo", u_if.lo, 32'd0);
        check("rst_div0", {31'b0, u_if.div0}, 32'd0);
        reset = 1'b0;

        // 1: MULTU max*max with exact busy/done timing
        start_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, "t1_multu");
        bad = 0;
        for (int i = 1; i <= 32; i++) begin
            @(negedge clk);
            if (u_if.busy !== 1'b1 || u_if.done !== 1'b0) bad++;
        end
        check("t1_busy_window_bad_cycles", bad, 32'd0);
        @(negedge clk);
        check("t1_cycle33_busy_done", {30'b0, u_if.busy, u_if.done}, 32'd1);

        // 2: signed multiply, then back-to-back signed divides
        start_op(2'b00, -32'sd3, 32'sd5, 1, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, "t2_mult");
        wait_done("t2_mult");
        start_op(2'b10, -32'sd7, 32'sd2, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, "t2_div");
        @(negedge clk);
        check("t2_start_in_done_cycle_busy", {31'b0, u_if.busy}, 32'd1);
        wait_done("t2_div");
        start_op(2'b10, 32'sd7, -32'sd2, 1, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, "t2_div_negb");
        wait_done("t2_div_negb");

        // 3: divide by zero, flag hold, then normal DIVU
        start_op(2'b11, 32'd100, 32'd0, 1, 32'h0000_0064, 32'hFFFF_FFFF, DZ, "t3_divu0");
        wait_done("t3_divu0");
        @(negedge clk);
        check("t3_div0_hold", {31'b0, u_if.div0}, {31'b0, DZ});
        start_op(2'b11, 32'd100, 32'd7, 1, 32'd2, 32'd14, 1'b0, "t3_divu");
        wait_done("t3_divu");

        // 4: most-negative / -1
        start_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h0, 32'h8000_0000, 1'b0, "t4_div_ovf");
        wait_done("t4_div_ovf");

        // 5: reset mid-operation discards it
        start_op(2'b01, 32'd3, 32'd4, 0, '0, '0, 1'b0, "t5_aborted");
        repeat (9) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("t5_busy_after_reset", {31'b0, u_if.busy}, 32'd0);
        check("t5_hi_after_reset", u_if.hi, 32'd0);
        check("t5_lo_after_reset", u_if.lo, 32'd0);
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (u_if.done) dones++;
        end
        check("t5_no_done_pulses", dones, 32'd0);
        start_op(2'b01, 32'd3, 32'd4, 1, 32'd0, 32'd12, 1'b0, "t5_multu");
        wait_done("t5_multu");

        // 6: start and hi_we while busy are ignored
        start_op(2'b01, 32'd6, 32'd7, 1, 32'd0, 32'd42, 1'b0, "t6_multu");
        repeat (4) @(posedge clk);
        #1;
        u_if.op = 2'b01; u_if.A = 32'd2; u_if.B = 32'd2; u_if.start = 1'b1;
        u_if.hi_we = 1'b1; u_if.wdata = 32'hAA;
        @(posedge clk);
        #1 u_if.start = 1'b0; u_if.hi_we = 1'b0;
        wait_done("t6_multu");
        u_if.hi_we = 1'b1; u_if.wdata = 32'hAA;
        @(posedge clk);
        #1 u_if.hi_we = 1'b0;
        @(negedge clk);
        check("t6_mthi_idle", u_if.hi, 32'hAA);
        u_if.hi_we = 1'b1; u_if.wdata = 32'hBB;
        start_op(2'b01, 32'd5, 32'd5, 1, 32'd0, 32'd25, 1'b0, "t6_start_beats_mthi");
        u_if.hi_we = 1'b0;
        @(negedge clk);
        check("t6_hi_hold_in_run", u_if.hi, 32'hAA);
        wait_done("t6_start_beats_mthi");
        u_if.hi_we = 1'b1; u_if.lo_we = 1'b1; u_if.wdata = 32'h1234;
        @(posedge clk);
        #1 u_if.hi_we = 1'b0; u_if.lo_we = 1'b0;
        @(negedge clk);
        check("t6_both_we_hi", u_if.hi, 32'h1234);
        check("t6_both_we_lo", u_if.lo, 32'h1234);

        repeat (3) @(negedge clk);
        check("sb_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
